// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Feeds the ALU operands, opcode and the store data path for the EX stage.
module id_ex_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_id_valid,
   input  logic [XLEN-1:0]   i_id_pc,
   input  logic [XLEN-1:0]   i_id_rs1_data,
   input  logic [XLEN-1:0]   i_id_rs2_data,
   input  logic [XLEN-1:0]   i_id_imm,
   input  logic [REG_AW-1:0] i_id_rs1_addr,
   input  logic [REG_AW-1:0] i_id_rs2_addr,
   input  logic [REG_AW-1:0] i_id_rd_addr,
   input  logic              i_id_uses_rs2,
   input  logic [3:0]        i_id_alu_ctrl,
   input  logic              i_id_alu_src_imm,
   input  logic              i_id_alu_src_pc,
   input  logic              i_id_reg_write,
   input  logic              i_id_mem_read,
   input  logic              i_id_mem_write,
   input  logic              i_id_branch,
   input  logic [REG_AW-1:0] i_exm_rd,
   input  logic              i_exm_reg_write,
   input  logic [XLEN-1:0]   i_exm_result,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   input  logic [XLEN-1:0]   i_wb_data,
   output logic [XLEN-1:0]   o_alu_a,
   output logic [XLEN-1:0]   o_alu_b,
   output logic [3:0]        o_alu_ctrl,
   output logic [XLEN-1:0]   o_ex_store_data,
   output logic [XLEN-1:0]   o_ex_pc,
   output logic [REG_AW-1:0] o_ex_rd,
   output logic              o_ex_valid,
   output logic              o_ex_reg_write,
   output logic              o_ex_mem_read,
   output logic              o_ex_mem_write,
   output logic              o_ex_branch,
   output logic              o_load_use_stall
);

   localparam logic [3:0] AluAdd = 4'b0000;

   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [REG_AW-1:0] r_rs1_addr;
   logic [REG_AW-1:0] r_rs2_addr;
   logic [REG_AW-1:0] r_rd;
   logic [3:0]        r_alu_ctrl;
   logic              r_alu_src_imm;
   logic              r_alu_src_pc;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_branch;

   logic              w_load_use;
   logic              w_bubble;
   logic              w_capture;
   logic [XLEN-1:0]   w_fwd_rs1;
   logic [XLEN-1:0]   w_fwd_rs2;

   // Load-use hazard: a load in EX whose destination is read by the decode slot.
   // A bubble in EX has r_valid=0, which forces this low.
   always_comb begin
      w_load_use = r_valid && r_mem_read && (r_rd != '0) && i_id_valid &&
                   ((r_rd == i_id_rs1_addr) || (i_id_uses_rs2 && (r_rd == i_id_rs2_addr)));
   end

   // Update priority: reset, flush, stall (hold), load-use bubble, capture.
   // An invalid decode slot is captured as a bubble so no control bit leaks through.
   always_comb begin
      w_bubble  = i_rst || i_flush || (!i_stall && (w_load_use || !i_id_valid));
      w_capture = !w_bubble && !i_stall;
   end

   // EX pipeline register.
   always_ff @(posedge i_clk) begin
      if (w_bubble) begin
         r_valid       <= 1'b0;
         r_pc          <= '0;
         r_rs1_data    <= '0;
         r_rs2_data    <= '0;
         r_imm         <= '0;
         r_rs1_addr    <= '0;
         r_rs2_addr    <= '0;
         r_rd          <= '0;
         r_alu_ctrl    <= AluAdd;
         r_alu_src_imm <= 1'b0;
         r_alu_src_pc  <= 1'b0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_branch      <= 1'b0;
      end else if (w_capture) begin
         r_valid       <= i_id_valid;
         r_pc          <= i_id_pc;
         r_rs1_data    <= i_id_rs1_data;
         r_rs2_data    <= i_id_rs2_data;
         r_imm         <= i_id_imm;
         r_rs1_addr    <= i_id_rs1_addr;
         r_rs2_addr    <= i_id_rs2_addr;
         r_rd          <= i_id_rd_addr;
         r_alu_ctrl    <= i_id_alu_ctrl;
         r_alu_src_imm <= i_id_alu_src_imm;
         r_alu_src_pc  <= i_id_alu_src_pc;
         r_reg_write   <= i_id_reg_write & i_id_valid;
         r_mem_read    <= i_id_mem_read & i_id_valid;
         r_mem_write   <= i_id_mem_write & i_id_valid;
         r_branch      <= i_id_branch & i_id_valid;
      end
   end

   // Operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
   always_comb begin
      w_fwd_rs1 = r_rs1_data;
      if (i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == r_rs1_addr)) begin
         w_fwd_rs1 = i_exm_result;
      end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == r_rs1_addr)) begin
         w_fwd_rs1 = i_wb_data;
      end
      w_fwd_rs2 = r_rs2_data;
      if (i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == r_rs2_addr)) begin
         w_fwd_rs2 = i_exm_result;
      end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == r_rs2_addr)) begin
         w_fwd_rs2 = i_wb_data;
      end
   end

   // Operand muxes and registered outputs.
   always_comb begin
      o_alu_a          = r_alu_src_pc ? r_pc : w_fwd_rs1;
      o_alu_b          = r_alu_src_imm ? r_imm : w_fwd_rs2;
      o_ex_store_data  = w_fwd_rs2;
      o_alu_ctrl       = r_alu_ctrl;
      o_ex_pc          = r_pc;
      o_ex_rd          = r_rd;
      o_ex_valid       = r_valid;
      o_ex_reg_write   = r_reg_write;
      o_ex_mem_read    = r_mem_read;
      o_ex_mem_write   = r_mem_write;
      o_ex_branch      = r_branch;
      o_load_use_stall = w_load_use;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// compared against a behavioural model of the EX register contents.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        id_uses_rs2;
   logic [3:0]  id_alu_ctrl;
   logic        id_alu_src_imm, id_alu_src_pc;
   logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
   logic [4:0]  exm_rd;
   logic        exm_reg_write;
   logic [31:0] exm_result;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [31:0] wb_data;
   logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
   logic [3:0]  alu_ctrl;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
   logic        load_use_stall;

   int n_vec = 0;
   int n_err = 0;

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
      .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data),
      .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm), .i_id_rs1_addr(id_rs1_addr),
      .i_id_rs2_addr(id_rs2_addr), .i_id_rd_addr(id_rd_addr), .i_id_uses_rs2(id_uses_rs2),
      .i_id_alu_ctrl(id_alu_ctrl), .i_id_alu_src_imm(id_alu_src_imm),
      .i_id_alu_src_pc(id_alu_src_pc), .i_id_reg_write(id_reg_write),
      .i_id_mem_read(id_mem_read), .i_id_mem_write(id_mem_write), .i_id_branch(id_branch),
      .i_exm_rd(exm_rd), .i_exm_reg_write(exm_reg_write), .i_exm_result(exm_result),
      .i_wb_rd(wb_rd), .i_wb_reg_write(wb_reg_write), .i_wb_data(wb_data),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
      .o_ex_store_data(ex_store_data), .o_ex_pc(ex_pc), .o_ex_rd(ex_rd),
      .o_ex_valid(ex_valid), .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
      .o_ex_mem_write(ex_mem_write), .o_ex_branch(ex_branch),
      .o_load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   // Model of what the EX slot holds: an instruction record, or all-zero for a bubble.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  ctrl;
      logic        simm, spc, rw, mr, mw, br;
   } ex_t;

   ex_t m = '0;

   function automatic logic model_lus();
      return m.valid && m.mr && (m.rd != 0) && id_valid &&
             ((m.rd == id_rs1_addr) || (id_uses_rs2 && (m.rd == id_rs2_addr)));
   endfunction

   function automatic ex_t model_next();
      ex_t n;
      if (rst || flush) return '0;
      if (stall) return m;
      if (model_lus() || !id_valid) return '0;
      n = '{valid: 1'b1, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm,
            rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr, ctrl: id_alu_ctrl,
            simm: id_alu_src_imm, spc: id_alu_src_pc, rw: id_reg_write, mr: id_mem_read,
            mw: id_mem_write, br: id_branch};
      return n;
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
      if (a == 0) return rf;
      if (exm_reg_write && exm_rd == a) return exm_result;
      if (wb_reg_write && wb_rd == a) return wb_data;
      return rf;
   endfunction

   // Advance one clock, updating the model from the inputs the DUT samples.
   task automatic step();
      ex_t n;
      n = model_next();
      @(posedge clk);
      m = n;
      #1;
   endtask

   task automatic set_id_idle();
      id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_uses_rs2 = 1'b0;
      id_alu_ctrl = '0; id_alu_src_imm = 1'b0; id_alu_src_pc = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0;
      exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
      wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
   endtask

   task automatic rand_id();
      id_valid = ($urandom_range(0, 4) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7)); id_uses_rs2 = 1'($urandom);
      id_alu_ctrl = 4'($urandom); id_alu_src_imm = 1'($urandom); id_alu_src_pc = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_branch = 1'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_id();
      step();
      rand_id();
      step();
      n_vec++; if (ex_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_valid got %b want 0", ex_valid); end
      n_vec++; if (alu_ctrl !== 4'b0000) begin n_err++;
         $display("FAIL reset_alu_ctrl got %b want 0000", alu_ctrl); end
      n_vec++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_err++;
         $display("FAIL reset_operands got a=%h b=%h want 0", alu_a, alu_b); end
      n_vec++; if (load_use_stall !== 1'b0) begin n_err++;
         $display("FAIL reset_lus got %b want 0", load_use_stall); end
      n_vec++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_pc, ex_rd} !== '0)
         begin n_err++; $display("FAIL reset_ctrl got %b%b%b%b pc=%h rd=%0d want 0",
            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_pc, ex_rd); end
      rst = 1'b0;
   endtask

   task automatic test_capture();
      set_id_idle();
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd9;
      id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_alu_ctrl = 4'b0001; id_reg_write = 1'b1;
      step();
      n_vec++; if (alu_a !== 32'd5) begin n_err++;
         $display("FAIL capture_alu_a got %h want 5", alu_a); end
      n_vec++; if (alu_b !== 32'd7) begin n_err++;
         $display("FAIL capture_alu_b got %h want 7", alu_b); end
      n_vec++; if (alu_ctrl !== 4'b0001) begin n_err++;
         $display("FAIL capture_alu_ctrl got %b want 0001", alu_ctrl); end
      n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_reg_write !== 1'b1) begin n_err++;
         $display("FAIL capture_ctrl got v=%b rd=%0d rw=%b want 1/9/1",
                  ex_valid, ex_rd, ex_reg_write); end
   endtask

   task automatic test_forward();
      set_id_idle();
      id_valid = 1'b1; id_rs1_addr = 5'd3; id_rs1_data = 32'h11;
      step();
      exm_rd = 5'd3; exm_result = 32'hAA; exm_reg_write = 1'b1;
      wb_rd = 5'd3; wb_data = 32'hBB; wb_reg_write = 1'b1;
      #1;
      n_vec++; if (alu_a !== 32'hAA) begin n_err++;
         $display("FAIL fwd_exm_priority got %h want aa", alu_a); end
      exm_reg_write = 1'b0;
      #1;
      n_vec++; if (alu_a !== 32'hBB) begin n_err++;
         $display("FAIL fwd_wb got %h want bb", alu_a); end
      id_rs1_addr = 5'd0; id_rs1_data = 32'h33;
      exm_rd = 5'd0; exm_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1;
      step();
      n_vec++; if (alu_a !== 32'h33) begin n_err++;
         $display("FAIL fwd_x0 got %h want 33", alu_a); end
   endtask

   task automatic test_load_use();
      set_id_idle();
      id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd4;
      id_rs1_addr = 5'd1;
      step();
      set_id_idle();
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd4; id_uses_rs2 = 1'b1;
      id_rd_addr = 5'd5; id_rs2_data = 32'h77; id_reg_write = 1'b1;
      #1;
      n_vec++; if (load_use_stall !== 1'b1) begin n_err++;
         $display("FAIL lu_detect got %b want 1", load_use_stall); end
      step();
      n_vec++; if (ex_valid !== 1'b0 || load_use_stall !== 1'b0) begin n_err++;
         $display("FAIL lu_bubble got v=%b lus=%b want 0/0", ex_valid, load_use_stall); end
      step();
      n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin n_err++;
         $display("FAIL lu_capture got v=%b rd=%0d want 1/5", ex_valid, ex_rd); end
      n_vec++; if (alu_b !== 32'h77) begin n_err++;
         $display("FAIL lu_alu_b got %h want 77", alu_b); end
   endtask

   task automatic test_stall_flush();
      set_id_idle();
      id_valid = 1'b1; id_pc = 32'h200; id_alu_ctrl = 4'b0100; id_rd_addr = 5'd7;
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         id_mem_read = 1'b0;
         step();
         n_vec++; if (ex_pc !== 32'h200 || alu_ctrl !== 4'b0100 || ex_valid !== 1'b1 ||
                      ex_rd !== 5'd7) begin n_err++;
            $display("FAIL stall_hold[%0d] got pc=%h ctrl=%b v=%b rd=%0d want 200/0100/1/7",
                     i, ex_pc, alu_ctrl, ex_valid, ex_rd); end
      end
      flush = 1'b1;
      step();
      n_vec++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || alu_ctrl !== 4'b0000) begin n_err++;
         $display("FAIL stall_flush got v=%b pc=%h ctrl=%b want 0/0/0000",
                  ex_valid, ex_pc, alu_ctrl); end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_src_select();
      set_id_idle();
      id_valid = 1'b1; id_alu_src_pc = 1'b1; id_alu_src_imm = 1'b1; id_pc = 32'h100;
      id_imm = 32'h10; id_rs1_addr = 5'd2; id_rs2_addr = 5'd6; id_rs2_data = 32'h99;
      id_mem_write = 1'b1;
      step();
      exm_rd = 5'd6; exm_result = 32'h55; exm_reg_write = 1'b1;
      #1;
      n_vec++; if (alu_a !== 32'h100) begin n_err++;
         $display("FAIL src_pc got %h want 100", alu_a); end
      n_vec++; if (alu_b !== 32'h10) begin n_err++;
         $display("FAIL src_imm got %h want 10", alu_b); end
      n_vec++; if (ex_store_data !== 32'h55) begin n_err++;
         $display("FAIL store_fwd_exm got %h want 55", ex_store_data); end
      exm_reg_write = 1'b0; wb_rd = 5'd6; wb_data = 32'h66; wb_reg_write = 1'b1;
      #1;
      n_vec++; if (ex_store_data !== 32'h66 || ex_mem_write !== 1'b1) begin n_err++;
         $display("FAIL store_fwd_wb got %h mw=%b want 66/1", ex_store_data, ex_mem_write); end
   endtask

   task automatic test_random();
      logic [142:0] got, exp;
      for (int i = 0; i < 400; i++) begin
         rand_id();
         rst = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 5) == 0);
         exm_rd = 5'($urandom_range(0, 7)); exm_reg_write = 1'($urandom); exm_result = $urandom;
         wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom); wb_data = $urandom;
         #1;
         exp = {(m.spc ? m.pc : fwd(m.rs1, m.rs1d)), (m.simm ? m.imm : fwd(m.rs2, m.rs2d)),
                fwd(m.rs2, m.rs2d), m.pc, m.ctrl, m.rd, m.valid, m.rw, m.mr, m.mw, m.br,
                model_lus()};
         got = {alu_a, alu_b, ex_store_data, ex_pc, alu_ctrl, ex_rd, ex_valid, ex_reg_write,
                ex_mem_read, ex_mem_write, ex_branch, load_use_stall};
         n_vec++; if (got !== exp) begin n_err++;
            $display("FAIL random[%0d] got %h want %h", i, got, exp); end
         step();
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id_idle();
      test_reset();
      test_capture();
      test_forward();
      test_load_use();
      test_stall_flush();
      test_src_select();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control from decode, then selects forwarded values from EX/MEM and MEM/WB.
- Drives the ALU A, B and alu_ctrl inputs.
- Detects load-use hazards and inserts a bubble for them; also handles external stall (hold) and flush (bubble).

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold EX register contents (downstream busy)
flush  in  1  replace EX contents with bubble (branch redirect)
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  register indices
id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
id_alu_ctrl  in  4  ADD 0000, SUB 0001, AND 0010, OR 0100, XOR 1000, SRL 1001, SLL 1010, SRA 1011
id_alu_src_imm  in  1  B = immediate instead of rs2
id_alu_src_pc  in  1  A = PC instead of rs1
id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control bits
exm_rd  in  REG_AW  EX/MEM destination
exm_reg_write  in  1  EX/MEM writes a register
exm_result  in  XLEN  EX/MEM ALU result
wb_rd  in  REG_AW  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes a register
wb_data  in  XLEN  MEM/WB write-back data
alu_a, alu_b  out  XLEN  ALU operands
alu_ctrl  out  4  registered ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_pc  out  XLEN  registered PC
ex_rd  out  REG_AW  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered control
load_use_stall  out  1  combinational; decode/fetch must hold this cycle

Behaviour:
- Bubble definition: valid=0; reg_write, mem_read, mem_write and branch all 0; alu_ctrl=ADD; rd=0; data fields 0.
- Register update priority on each rising clk edge:
  1. rst=1: bubble; all outputs read 0.
  2. flush=1: bubble. Flush wins over stall and load_use_stall.
  3. stall=1: hold every field unchanged.
  4. load_use_stall=1: bubble. Decode holds the same instruction, which is captured on the next non-hazard cycle.
  5. Otherwise: capture all id_* fields.
- Every control bit is masked with id_valid at capture, so a captured invalid slot equals a bubble.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd≠0) & ((ex_rd==id_rs1_addr) | (id_uses_rs2 & ex_rd==id_rs2_addr)) & id_valid.
  - Forced to 0 while the EX register is reset or holds a bubble.
- Forwarding is combinational on the registered rs1/rs2 fields, evaluated per operand:
  - If exm_reg_write & exm_rd≠0 & exm_rd==rs: use exm_result.
  - Else if wb_reg_write & wb_rd≠0 & wb_rd==rs: use wb_data.
  - Else: use the registered register-file data.
  - x0 is never forwarded. EX/MEM has priority over MEM/WB.
- Operand muxes:
  - alu_a = alu_src_pc ? ex_pc : fwd_rs1.
  - alu_b = alu_src_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always, regardless of alu_src_imm.
- Latency: an id_* value appears on EX outputs 1 cycle after capture. Forwarded operands update in the same cycle as the exm/wb inputs change (zero-latency combinational path).
- Reset mid-stall or mid-hazard: rst wins and produces a bubble. load_use_stall deasserts in the cycle after reset.
- No arithmetic in this block; all widths are XLEN with no extension.

Test Plan:
- Reset: rst=1 for 2 cycles with random id_* inputs → ex_valid=0, alu_ctrl=0000, alu_a=alu_b=0, load_use_stall=0.
- Plain capture: id_rs1_data=5, id_rs2_data=7, alu_ctrl=0001, no forwarding matches → next cycle alu_a=5, alu_b=7, alu_ctrl=0001, ex_valid=1.
- Forward priority: EX rs1=x3, exm_rd=3/exm_result=0xAA, wb_rd=3/wb_data=0xBB, both write-enabled → alu_a=0xAA. Drop exm_reg_write → alu_a=0xBB. Set rs1=x0 with exm_rd=0 → register-file data used.
- Load-use: EX holds lw x4 (mem_read=1, rd=4), decode has add using rs2=x4 with id_uses_rs2=1 → load_use_stall=1; next cycle ex_valid=0; following cycle the add is captured.
- Stall vs flush: stall=1 for 3 cycles → outputs constant. stall=1 & flush=1 → bubble on next edge.
- Immediate/PC select: alu_src_pc=1, alu_src_imm=1, pc=0x100, imm=0x10, rs2 forwarded 0x55 → alu_a=0x100, alu_b=0x10, ex_store_data=0x55.
